// File: rtl/uart_pkg.sv
// Shared types and frame-timing constants for the UART transmit scheduler.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } sched_state_t;

   localparam int unsigned BIT_CLK_DEF = 87;
   localparam int unsigned FRAME_BITS  = 10;
   localparam int unsigned GUARD_CLKS  = 2;

   // One full frame (start + 8 data + stop) plus guard cycles.
   function automatic int unsigned frame_clks(input int unsigned bit_clk);
      return FRAME_BITS * bit_clk + GUARD_CLKS;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr (ascending, wrapping) wins.
module rr_arbiter #(
   parameter int unsigned WIDTH = 4,
   localparam int unsigned IW = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [WIDTH-1:0] gnt,
   output logic [IW-1:0]    idx,
   output logic             any
);

   logic found;
   int   k;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      k     = 0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         k = (int'(ptr) + i) % int'(WIDTH);
         if (!found && req[k]) begin
            found  = 1'b1;
            gnt[k] = 1'b1;
            idx    = IW'(k);
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers.
// Define UART_TX_SCHED_PRIO_EN to give requester 0 strict priority over the round robin.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned BIT_CLK    = BIT_CLK_DEF,
   parameter int unsigned FRAME_CLKS = frame_clks(BIT_CLK)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*8-1:0]       req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       tx_cts,
   output logic [7:0]                 tx_data,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id
);

   localparam int unsigned IW = $clog2(NUM_REQ);
   localparam int unsigned CW = $clog2(FRAME_CLKS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_CLKS - 1);

   sched_state_t        state;
   logic [IW-1:0]       ptr;
   logic [CW-1:0]       cnt;
   logic [NUM_REQ-1:0]  arb_req;
   logic [NUM_REQ-1:0]  arb_gnt;
   logic [IW-1:0]       arb_idx;
   logic                arb_any;
   logic [NUM_REQ-1:0]  win_oh;
   logic [IW-1:0]       win_idx;
   logic                any_req;
   logic                ptr_adv;

   rr_arbiter #(
      .WIDTH (NUM_REQ)
   ) u_arb (
      .req (arb_req),
      .ptr (ptr),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

`ifdef UART_TX_SCHED_PRIO_EN
   // Requester 0 bypasses the ring; the rest share the pointer.
   assign arb_req = req_valid & ~NUM_REQ'(1);
   assign win_oh  = req_valid[0] ? NUM_REQ'(1) : arb_gnt;
   assign win_idx = req_valid[0] ? '0 : arb_idx;
   assign any_req = req_valid[0] | arb_any;
   assign ptr_adv = !req_valid[0];
`else
   assign arb_req = req_valid;
   assign win_oh  = arb_gnt;
   assign win_idx = arb_idx;
   assign any_req = arb_any;
   assign ptr_adv = 1'b1;
`endif

   assign req_ready = (state == IDLE) ? win_oh : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         tx_cts   <= 1'b0;
         tx_data  <= 8'h00;
         busy     <= 1'b0;
         grant_id <= '0;
         ptr      <= '0;
         cnt      <= '0;
      end else begin
         tx_cts <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  tx_data  <= req_data[int'(win_idx)*8 +: 8];
                  grant_id <= win_idx;
                  if (ptr_adv) begin
                     ptr <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
                  end
                  tx_cts   <= 1'b1;
                  busy     <= 1'b1;
                  state    <= START;
               end
            end
            START: begin
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (cnt == CNT_LAST) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched against a time-based slot model; honours UART_TX_SCHED_PRIO_EN.
module tb_uart_tx_sched;

   localparam int N     = 4;
   localparam int FRAME = 872;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   req_valid;
   logic [31:0]  req_data;
   logic [3:0]   req_ready;
   logic         tx_cts;
   logic [7:0]   tx_data;
   logic         busy;
   logic [1:0]   grant_id;

   always #5 clk = ~clk;

   uart_tx_sched #(
      .NUM_REQ (N),
      .BIT_CLK (87)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .tx_cts    (tx_cts),
      .tx_data   (tx_data),
      .busy      (busy),
      .grant_id  (grant_id)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model: a grant at cycle g owns the transmitter until cycle g+FRAME+2.
   int         cyc       = 0;
   int         free_at   = 0;
   int         grant_cyc = -10000;
   int         ptr       = 0;
   int         exp_id    = 0;
   logic [7:0] exp_data  = 8'h00;
   bit         refill    = 1'b0;

   int obs_id[$];
   int obs_cyc[$];
   int cts_cnt       = 0;
   int busy_run      = 0;
   int last_busy_len = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int pick(input logic [3:0] v, input int p);
`ifdef UART_TX_SCHED_PRIO_EN
      if (v[0]) return 0;
`endif
      for (int i = 0; i < N; i++) begin
         int k;
         k = (p + i) % N;
`ifdef UART_TX_SCHED_PRIO_EN
         if (k == 0) continue;
`endif
         if (v[k]) return k;
      end
      return -1;
   endfunction

   task automatic step();
      int         w;
      logic [3:0] er;
      @(negedge clk);
      w = (cyc >= free_at) ? pick(req_valid, ptr) : -1;
      if (!reset) begin
         er = (w >= 0) ? 4'(1 << w) : 4'b0000;
         chk("req_ready", req_ready, er);
         chk("tx_cts", tx_cts, cyc == grant_cyc + 1);
         chk("busy", busy, (cyc > grant_cyc) && (cyc < free_at));
         chk("tx_data", tx_data, exp_data);
         chk("grant_id", grant_id, exp_id);
         if (tx_cts) cts_cnt++;
         if (busy) busy_run++;
         else if (busy_run != 0) begin
            last_busy_len = busy_run;
            busy_run      = 0;
         end
         for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
               obs_id.push_back(i);
               obs_cyc.push_back(cyc);
            end
         end
      end
      if (reset) begin
         exp_data  = 8'h00;
         exp_id    = 0;
         ptr       = 0;
         free_at   = cyc + 1;
         grant_cyc = -10000;
         busy_run  = 0;
      end else if (w >= 0) begin
         exp_data = req_data[w*8 +: 8];
         exp_id   = w;
`ifdef UART_TX_SCHED_PRIO_EN
         if (w != 0) ptr = (w + 1) % N;
`else
         ptr = (w + 1) % N;
`endif
         grant_cyc = cyc;
         free_at   = cyc + FRAME + 2;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!reset && w >= 0) begin
         if (refill) req_data[w*8 +: 8] = 8'($urandom);
         else req_valid[w] = 1'b0;
      end
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic wait_idle();
      while (cyc < free_at) step();
      step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic clear_obs();
      obs_id.delete();
      obs_cyc.delete();
      cts_cnt = 0;
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_data  = '0;
      @(posedge clk);
      #1;
      run(3);
      reset = 1'b0;
      chk("rst_busy", busy, 1'b0);
      chk("rst_cts", tx_cts, 1'b0);
      chk("rst_data", tx_data, 8'h00);
      chk("rst_gid", grant_id, 2'd0);
      chk("rst_ready", req_ready, 4'b0000);
      step();

      // Lone requester 0 offering 0x55.
      clear_obs();
      req_data[7:0] = 8'h55;
      req_valid     = 4'b0001;
      step();
      chk("t1_data", tx_data, 8'h55);
      chk("t1_cts", tx_cts, 1'b1);
      wait_idle();
      chk("t1_busy_len", last_busy_len, FRAME + 1);
      chk("t1_ngrant", obs_id.size(), 1);
      chk("t1_ncts", cts_cnt, 1);

      // All four held valid: 0,1,2,3,0 spaced FRAME+2 apart.
      do_reset();
      clear_obs();
      refill    = 1'b1;
      req_data  = $urandom;
      req_valid = 4'b1111;
      run(4 * (FRAME + 2) + 1);
      req_valid = '0;
      refill    = 1'b0;
      wait_idle();
      chk("t2_ngrant", obs_id.size(), 5);
      if (obs_id.size() == 5) begin
         for (int i = 0; i < 5; i++) begin
            chk("t2_order", obs_id[i], i % 4);
            if (i > 0) chk("t2_spacing", obs_cyc[i] - obs_cyc[i-1], FRAME + 2);
         end
      end

      // Pointer at 3 with requesters 2 and 3 valid.
      do_reset();
      req_data  = $urandom;
      req_valid = 4'b0100;
      step();
      wait_idle();
      clear_obs();
      req_valid = 4'b1100;
      step();
      wait_idle();
      step();
      wait_idle();
      chk("t3_ngrant", obs_id.size(), 2);
      if (obs_id.size() == 2) begin
         chk("t3_first", obs_id[0], 3);
         chk("t3_second", obs_id[1], 2);
      end

      // Reset in the middle of WAIT.
      do_reset();
      req_data  = $urandom;
      req_valid = 4'b0001;
      step();
      run(401);
      reset     = 1'b1;
      req_valid = 4'b0011;
      step();
      reset = 1'b0;
      chk("t4_busy", busy, 1'b0);
      chk("t4_cts", tx_cts, 1'b0);
      chk("t4_data", tx_data, 8'h00);
      chk("t4_gid", grant_id, 2'd0);
      clear_obs();
      step();
      chk("t4_winner", (obs_id.size() > 0) ? obs_id[0] : -1, 0);
      req_valid = '0;
      wait_idle();

      // Requester 1 withdraws during another slot's WAIT.
      clear_obs();
      req_data  = $urandom;
      req_valid = 4'b0100;
      step();
      run(50);
      req_valid[1] = 1'b1;
      run(100);
      req_valid[1] = 1'b0;
      wait_idle();
      run(5);
      chk("t5_ngrant", obs_id.size(), 1);
      chk("t5_ncts", cts_cnt, 1);

      // Requesters 0 and 2 held valid.
      do_reset();
      clear_obs();
      refill    = 1'b1;
      req_data  = $urandom;
      req_valid = 4'b0101;
      run(3 * (FRAME + 2) + 1);
      req_valid = '0;
      refill    = 1'b0;
      wait_idle();
      chk("t6_ngrant", obs_id.size(), 4);
      if (obs_id.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
`ifdef UART_TX_SCHED_PRIO_EN
            chk("t6_order", obs_id[i], 0);
`else
            chk("t6_order", obs_id[i], (i % 2 == 0) ? 0 : 2);
`endif
         end
      end

      // Random traffic against the model.
      for (int ph = 0; ph < 30; ph++) begin
         req_valid = 4'($urandom);
         req_data  = $urandom;
         refill    = 1'($urandom);
         run($urandom_range(50, 700));
      end
      req_valid = '0;
      refill    = 1'b0;
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART transmitter among `NUM_REQ` byte producers. Each requester offers a byte with a valid/ready handshake. The scheduler grants one requester per frame slot, presents the byte to the transmitter, and issues a one-cycle start strobe. It then blocks further grants for a fixed frame time so the transmitter is never restarted mid-frame. It sits between the command/status producers and the transmitter's `cts`/`txdata` inputs.

## Interface
- `NUM_REQ`, 4, number of requesters; legal range 2..8.
- `BIT_CLK`, 87, clocks per UART bit; used only to derive the `FRAME_CLKS` default.
- `FRAME_CLKS`, 10*BIT_CLK+2 (872), length of the post-start blocking window in clocks; must be ≥1.
- `clk` in 1 — clock.
- `reset` in 1 — reset, synchronous, active-high.
- `req_valid` in NUM_REQ — per-requester byte offer.
- `req_data` in NUM_REQ*8 — bytes; requester i occupies bits [8i+7:8i].
- `req_ready` out NUM_REQ — one-hot accept pulse; a byte is transferred when `valid[i] && ready[i]`.
- `tx_cts` out 1 — start strobe to the transmitter.
- `tx_data` out 8 — byte to the transmitter; held stable between grants.
- `busy` out 1 — a frame slot is in progress.
- `grant_id` out $clog2(NUM_REQ) — index of the last granted requester.

## Operation
- Three-state FSM: IDLE, START, WAIT.
- IDLE
  - If any `req_valid` is set, the arbiter picks winner `w`.
  - `req_ready[w]=1` combinationally in that cycle (Mealy). All other ready bits are 0.
  - On that clock: `req_data[w]` is registered into `tx_data`, `grant_id<=w`, round-robin pointer `<=w+1` (wraps to 0 after `NUM_REQ-1`), next state START.
  - If no `req_valid` is set, stay in IDLE with all outputs held.
- START: `tx_cts=1` for exactly this cycle; counter cleared; next state WAIT.
- WAIT
  - Counter increments from 0 to `FRAME_CLKS-1`, then returns to IDLE.
  - Counter width is `$clog2(FRAME_CLKS+1)`; it never wraps.
- Arbitration: the search starts at the pointer and proceeds in ascending index order with wrap. The first valid requester wins.
- `req_ready` is 0 in START and WAIT regardless of `req_valid`.
- Requester rules:
  - A requester must hold `valid` and `data` until it sees ready.
  - A requester that drops `valid` before it is granted is simply skipped; nothing is lost or duplicated.
- `tx_data` keeps the last granted byte until the next grant; it never returns to 0 outside reset.
- `busy` is 1 in START and WAIT, 0 in IDLE.
- Reset values: `req_ready=0`, `tx_cts=0`, `tx_data=8'h00`, `busy=0`, `grant_id=0`, pointer 0, counter 0, state IDLE.
- Reset asserted in any state (including mid-WAIT) aborts the slot immediately. The transmitter shares the same reset.

## Timing
- Grant handshake at cycle T.
- `tx_data` is valid and `tx_cts=1` at T+1.
- WAIT spans T+2 … T+1+FRAME_CLKS.
- IDLE resumes at T+2+FRAME_CLKS; a new grant is possible in that same cycle.
- Minimum grant-to-grant spacing: `FRAME_CLKS+2` cycles (874 at defaults).
- `busy` is high for `FRAME_CLKS+1` consecutive cycles per grant.
- When `valid` rises in IDLE, acceptance latency is 0 cycles.
- Worst-case wait for a continuously valid requester: `NUM_REQ-1` slots.

## Configuration
- `UART_TX_SCHED_PRIO_EN` defined:
  - Requester 0 has strict priority; whenever `req_valid[0]` is set in IDLE, it wins.
  - Requesters 1..NUM_REQ-1 round-robin among themselves; the pointer is untouched by requester-0 grants.
- Undefined: pure round-robin across all requesters, as described above.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, WAIT);
  - `BIT_CLK` default;
  - frame-length constant (10 bits + 2 guard cycles).
- Sub-module `rr_arbiter`:
  - inputs: request vector, pointer;
  - outputs: one-hot grant, encoded index, any-request flag;
  - purely combinational, parameterised by width.

## Test plan
- Request 0 offers 8'h55 alone → `req_ready[0]` pulses 1 cycle; `tx_data=8'h55` and `tx_cts=1` next cycle; `busy` high for 873 cycles.
- All four requesters held valid → grant order 0,1,2,3,0 with grants exactly 874 cycles apart; `grant_id` tracks each grant.
- Pointer at 3 with requesters 2 and 3 valid → 3 granted first, then 2.
- Reset pulsed at WAIT count 400 → next cycle `busy=0`, `tx_cts=0`, `tx_data=0`, `grant_id=0`. After release, requester 0 wins.
- Requester 1 drops `valid` during another requester's WAIT → it is never readied, and no extra `tx_cts` is issued.
- With `UART_TX_SCHED_PRIO_EN`, requesters 0 and 2 held valid → requester 0 wins every slot. Without the macro, grants alternate 0,2,0,2.
